// File: rtl/vga_pkg.sv
// Shared VGA pattern definitions: display modes, 1-bit-per-channel colours
// and the colour-index mapping used by the cycling mode.
package vga_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    MODE_YELLOW  = 3'd0,
    MODE_VBARS   = 3'd1,
    MODE_HBARS   = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_BLOCK   = 3'd4,
    MODE_CYCLE   = 3'd5,
    MODE_OFF6    = 3'd6,
    MODE_OFF7    = 3'd7
  } mode_t;

  // Each flag expands to an all-ones or all-zero channel at the output.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = 3'b000;
  localparam rgb_t RGB_BLUE   = 3'b001;
  localparam rgb_t RGB_GREEN  = 3'b010;
  localparam rgb_t RGB_RED    = 3'b100;
  localparam rgb_t RGB_YELLOW = 3'b110;
  localparam rgb_t RGB_WHITE  = 3'b111;

  function automatic rgb_t idx_to_rgb(input logic [2:0] idx);
    return rgb_t'(idx);
  endfunction

endpackage

// File: rtl/vga_bounce_pos.sv
// One axis of the bouncing square: steps 1 pixel per frame tick,
// reversing direction when it sits at 0 or LIMIT.
module vga_bounce_pos
  import vga_pkg::*;
#(
  parameter int LIMIT = 608
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               step_i,
  output logic [COORD_W-1:0] pos_o
);

  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
  localparam logic [COORD_W-1:0] POS_MAX = COORD_W'(LIMIT);

  logic [COORD_W-1:0] pos_q, pos_d;
  logic               fwd_q, fwd_d;

  // At an edge the reversal and the step happen on the same tick.
  always_comb begin
    pos_d = pos_q;
    fwd_d = fwd_q;
    if (step_i) begin
      if (fwd_q && pos_q == POS_MAX) begin
        fwd_d = 1'b0;
        pos_d = pos_q - ONE;
      end else if (!fwd_q && pos_q == '0) begin
        fwd_d = 1'b1;
        pos_d = pos_q + ONE;
      end else if (fwd_q) begin
        pos_d = pos_q + ONE;
      end else begin
        pos_d = pos_q - ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
      fwd_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      fwd_q <= fwd_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: picks a colour per pixel from the mode latched at
// frame start; outputs are registered, one clock behind hCount/vCount/blank.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAR_SHIFT  = 4,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [2:0]            sw,
  input  logic [COORD_W-1:0]    hCount,
  input  logic [COORD_W-1:0]    vCount,
  input  logic                  blank,
  output logic [COLOR_BITS-1:0] vgaRed,
  output logic [COLOR_BITS-1:0] vgaGreen,
  output logic [COLOR_BITS-1:0] vgaBlue
);

  logic                  frame_tick;
  mode_t                 mode_q, mode_d;
  logic [5:0]            fcnt_q, fcnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [COORD_W-1:0]    bx, by;
  logic                  in_block;
  rgb_t                  pix;
  logic [COLOR_BITS-1:0] red_q, green_q, blue_q;

  assign frame_tick = (hCount == '0) && (vCount == COORD_W'(V_ACTIVE));

  vga_bounce_pos #(.LIMIT(H_ACTIVE - BLOCK_SIZE)) u_bounce_x (
    .clk_i  (clk_25mhz),
    .rst_ni (reset),
    .step_i (frame_tick),
    .pos_o  (bx)
  );

  vga_bounce_pos #(.LIMIT(V_ACTIVE - BLOCK_SIZE)) u_bounce_y (
    .clk_i  (clk_25mhz),
    .rst_ni (reset),
    .step_i (frame_tick),
    .pos_o  (by)
  );

  // One extra bit so bx + BLOCK_SIZE cannot wrap near the right edge.
  assign in_block = (hCount >= bx) &&
                    ({1'b0, hCount} < ({1'b0, bx} + (COORD_W+1)'(BLOCK_SIZE))) &&
                    (vCount >= by) &&
                    ({1'b0, vCount} < ({1'b0, by} + (COORD_W+1)'(BLOCK_SIZE)));

  always_comb begin
    mode_d = mode_q;
    fcnt_d = fcnt_q;
    idx_d  = idx_q;
    if (frame_tick) begin
      mode_d = mode_t'(sw);
      fcnt_d = fcnt_q + 6'd1;
      if (fcnt_q == 6'd63) idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    pix = RGB_BLACK;
    case (mode_q)
      MODE_YELLOW:  pix = RGB_YELLOW;
      MODE_VBARS:   pix = hCount[BAR_SHIFT] ? RGB_WHITE : RGB_RED;
      MODE_HBARS:   pix = vCount[BAR_SHIFT] ? RGB_BLUE : RGB_GREEN;
      MODE_CHECKER: pix = (hCount[BAR_SHIFT] ^ vCount[BAR_SHIFT]) ? RGB_BLACK : RGB_WHITE;
      MODE_BLOCK:   pix = in_block ? RGB_WHITE : RGB_BLACK;
      MODE_CYCLE:   pix = idx_to_rgb(idx_q);
      default:      pix = RGB_BLACK;
    endcase
    if (blank) pix = RGB_BLACK;
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_YELLOW;
      fcnt_q  <= '0;
      idx_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      red_q   <= {COLOR_BITS{pix.r}};
      green_q <= {COLOR_BITS{pix.g}};
      blue_q  <= {COLOR_BITS{pix.b}};
    end
  end

  assign vgaRed   = red_q;
  assign vgaGreen = green_q;
  assign vgaBlue  = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen against a frame-count based model.
module tb_vga_pattern_gen;

  localparam int HA = 640;
  localparam int VA = 480;
  localparam int BS = 32;

  logic        clk_25mhz;
  logic        reset;
  logic [2:0]  sw;
  logic [10:0] hCount;
  logic [10:0] vCount;
  logic        blank;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic [11:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int m_n      = 0;
  int m_mode   = 0;

  vga_pattern_gen dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .sw        (sw),
    .hCount    (hCount),
    .vCount    (vCount),
    .blank     (blank),
    .vgaRed    (vgaRed),
    .vgaGreen  (vgaGreen),
    .vgaBlue   (vgaBlue)
  );

  assign obs = {vgaRed, vgaGreen, vgaBlue};

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  // Square position after n ticks is a triangle wave of period 2*lim.
  function automatic int tri_pos(input int n, input int lim);
    int p;
    p = n % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [11:0] exp_rgb(input int mode, input int h, input int v,
                                          input bit blk, input int n);
    logic [2:0] c;
    int bx, by;
    c = 3'b000;
    bx = tri_pos(n, HA - BS);
    by = tri_pos(n, VA - BS);
    case (mode)
      0: c = 3'b110;
      1: c = (((h >> 4) & 1) != 0) ? 3'b111 : 3'b100;
      2: c = (((v >> 4) & 1) != 0) ? 3'b001 : 3'b010;
      3: c = ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 3'b000 : 3'b111;
      4: c = (h >= bx && h < bx + BS && v >= by && v < by + BS) ? 3'b111 : 3'b000;
      5: c = 3'((n / 64) % 8);
      default: c = 3'b000;
    endcase
    if (blk) c = 3'b000;
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  task automatic drive(input int h, input int v, input bit b);
    @(negedge clk_25mhz);
    hCount = 11'(h);
    vCount = 11'(v);
    blank  = b;
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic tick(input logic [2:0] s);
    sw = s;
    drive(0, VA, 1'b1);
    m_n++;
    m_mode = int'(s);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    reset = 1'b1;
    m_n = 0;
    m_mode = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; sw = 3'd3; hCount = 11'd100; vCount = 11'd100; blank = 1'b0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
    end
    @(negedge clk_25mhz);
    reset = 1'b1;
    m_n = 0; m_mode = 0;
  endtask

  task automatic test_yellow();
    logic [11:0] e;
    tick(3'd0);
    drive(100, 100, 1'b0);
    e = exp_rgb(m_mode, 100, 100, 1'b0, m_n);
    n_checks++;
    if (obs !== e || obs !== 12'hFF0) begin
      n_fail++;
      $display("FAIL yellow_100_100: got %h expected %h", obs, 12'hFF0);
    end
  endtask

  task automatic test_vbars();
    int hs[3] = '{15, 16, 16};
    bit bs[3] = '{1'b0, 1'b0, 1'b1};
    logic [11:0] e;
    tick(3'd1);
    for (int i = 0; i < 3; i++) begin
      drive(hs[i], 100, bs[i]);
      e = exp_rgb(m_mode, hs[i], 100, bs[i], m_n);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL vbars_h%0d_blank%0d: got %h expected %h", hs[i], bs[i], obs, e);
      end
    end
  endtask

  task automatic test_mode_latch();
    int vs[3] = '{200, 300, 479};
    int hs[2] = '{0, 16};
    logic [11:0] e;
    int h;
    tick(3'd0);
    sw = 3'd3;
    for (int i = 0; i < 3; i++) begin
      h = int'($urandom_range(0, HA - 1));
      drive(h, vs[i], 1'b0);
      e = exp_rgb(m_mode, h, vs[i], 1'b0, m_n);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL latch_midframe_v%0d: got %h expected %h", vs[i], obs, e);
      end
    end
    tick(3'd3);
    for (int i = 0; i < 2; i++) begin
      drive(hs[i], 16, 1'b0);
      e = exp_rgb(m_mode, hs[i], 16, 1'b0, m_n);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL checker_%0d_16: got %h expected %h", hs[i], obs, e);
      end
    end
  endtask

  task automatic test_bounce();
    int ox[5] = '{-1, 0, 31, 32, 0};
    int oy[5] = '{0, 0, 31, 0, -1};
    int stops[4] = '{448, 449, 608, 609};
    int bx, by, h, v;
    logic [11:0] e;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      while (m_n < stops[s]) tick(3'd4);
      bx = tri_pos(m_n, HA - BS);
      by = tri_pos(m_n, VA - BS);
      for (int k = 0; k < 5; k++) begin
        h = bx + ox[k];
        v = by + oy[k];
        drive(h, v, 1'b0);
        e = exp_rgb(m_mode, h, v, 1'b0, m_n);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL bounce_n%0d_px%0d_%0d: got %h expected %h", m_n, h, v, obs, e);
        end
      end
    end
  endtask

  task automatic test_color_cycle();
    logic [11:0] e;
    do_reset();
    for (int k = 1; k <= 512; k++) begin
      tick(3'd5);
      if (k == 1 || k == 63 || k == 64 || k == 128 || k == 511 || k == 512) begin
        drive(320, 240, 1'b0);
        e = exp_rgb(m_mode, 320, 240, 1'b0, m_n);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL color_cycle_tick%0d: got %h expected %h", k, obs, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ph[4] = '{0, 1, 32, 33};
    int pv[4] = '{0, 1, 32, 1};
    logic [11:0] e;
    do_reset();
    repeat (50) tick(3'd4);
    drive(60, 60, 1'b0);
    e = exp_rgb(m_mode, 60, 60, 1'b0, m_n);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL pre_reset_block: got %h expected %h", obs, e);
    end
    hCount = 11'd300; vCount = 11'd200;
    #5 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset_clear: got %h expected %h", obs, 12'h000);
    end
    @(negedge clk_25mhz);
    reset = 1'b1;
    m_n = 0; m_mode = 0;
    drive(300, 200, 1'b0);
    e = exp_rgb(m_mode, 300, 200, 1'b0, m_n);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_reset_mode0: got %h expected %h", obs, e);
    end
    tick(3'd4);
    for (int i = 0; i < 4; i++) begin
      drive(ph[i], pv[i], 1'b0);
      e = exp_rgb(m_mode, ph[i], pv[i], 1'b0, m_n);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_reset_block_%0d_%0d: got %h expected %h", ph[i], pv[i], obs, e);
      end
    end
  endtask

  task automatic test_random();
    int h, v;
    bit b;
    logic [11:0] e;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        tick(3'($urandom_range(0, 7)));
        n_checks++;
        if (obs !== 12'h000) begin
          n_fail++;
          $display("FAIL random_tick_blank: got %h expected %h", obs, 12'h000);
        end
      end else begin
        sw = 3'($urandom_range(0, 7));
        h = int'($urandom_range(0, HA - 1));
        v = int'($urandom_range(0, VA - 1));
        b = ($urandom_range(0, 7) == 0);
        drive(h, v, b);
        e = exp_rgb(m_mode, h, v, b, m_n);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL random_px_%0d_%0d_m%0d: got %h expected %h", h, v, m_mode, obs, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_yellow();
    test_vbars();
    test_mode_latch();
    test_bounce();
    test_color_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
